bin2pos_pipe: RTL
=================

// Module: bin2pos_pipe
// PURPOSE
// - Multi-channel, pipelined binary-to-position decoder with valid/ready flow control.
// - Each channel turns BIN_WIDTH-bit index i into a POS_WIDTH-bit vector: one-hot, or thermometer.
// - Flags indices that are out of range (i >= POS_WIDTH).
// - Sits between stream producers (RNG, counters, arbiters) and mask consumers; full throughput.
// PARAMETERS
// - BIN_WIDTH      4              index width per channel, >=1
// - POS_WIDTH      2**BIN_WIDTH   position vector width per channel, 1..2**BIN_WIDTH
// - CHANNELS       1              independent lanes sharing one handshake, >=1
// - ERR_CNT_WIDTH  16             width of the out-of-range beat counter (optional feature)
// PORTS
// - clk      in   1                     clock, all logic rising-edge
// - rst      in   1                     asynchronous reset, active high
// - mode     in   2                     00 one-hot; 01 thermo-incl; 10 thermo-excl; 11 reserved
// - s_valid  in   1                     input beat valid
// - s_ready  out  1                     input beat accepted when s_valid&s_ready
// - s_bin    in   CHANNELS*BIN_WIDTH    channel c index = s_bin[c*BIN_WIDTH +: BIN_WIDTH]
// - m_valid  out  1                     output beat valid
// - m_ready  in   1                     output beat consumed when m_valid&m_ready
// - m_pos    out  CHANNELS*POS_WIDTH    channel c vector = m_pos[c*POS_WIDTH +: POS_WIDTH]
// - m_oor    out  CHANNELS              per-channel out-of-range flag, same beat as m_pos
// - err_clr  in   1                     synchronous clear of err_cnt (feature only)
// - err_cnt  out  ERR_CNT_WIDTH         out-of-range beat count (feature only)
// BEHAVIOUR
// - Reset (async): m_valid=0, m_pos=0, m_oor=0, skid empty, s_ready=1, err_cnt=0.
// - Reset mid-stream: in-flight beats (output reg and skid) discarded; no partial beat is emitted.
// - Decode per channel, index i:
//   - 00 one-hot: bit k = (k==i).
//   - 01 thermo-incl: bit k = (k<=i).
//   - 10 thermo-excl: bit k = (k<i).
//   - 11 reserved: vector all zeros; m_oor unaffected.
// - Out of range (i >= POS_WIDTH):
//   - m_oor[c]=1.
//   - one-hot -> all zeros; thermo-incl and thermo-excl -> all ones.
// - mode is sampled together with s_bin on the accepting edge; it may change every beat.
// - Pipeline: one output register plus one-entry skid buffer.
//   - Latency: a beat accepted at edge N is visible at m_valid/m_pos after edge N.
//   - s_ready is registered: s_ready = skid empty.
//   - Throughput: 1 beat/clk while m_ready=1.
// - Handshake rules:
//   - While m_valid=1 and m_ready=0, m_pos and m_oor are held stable.
//   - m_valid never drops without a handshake.
//   - Stall: an accepted beat arriving while the output reg is full and stalled goes to the skid;
//     s_ready drops on the next edge.
//   - Drain: on m_ready with the skid full, the skid moves into the output reg; s_ready=1 next edge.
//   - Simultaneous accept and consume with the skid empty: the output reg reloads directly; no bubble.
// - Ordering: strictly in order; no beat lost or duplicated.
// CONFIGURATION
// - Macro BIN2POS_ERR_CNT_EN defined:
//   - err_cnt increments by 1 on each consumed beat (m_valid&m_ready) with |m_oor.
//   - err_cnt saturates at all-ones.
//   - err_clr zeroes err_cnt; if err_clr and a counted beat coincide, clear wins (result 0).
// - Macro not defined:
//   - No counter logic; err_cnt tied to 0; err_clr ignored.
// TESTING
// - Reset, then BIN_WIDTH=4/CHANNELS=1, mode=00, stream i=0..15 with m_ready=1
//   -> m_pos=1<<i one clk later, m_oor=0, 16 beats back-to-back.
// - mode=01, i=5 -> 16'h003F. mode=10, i=5 -> 16'h001F. mode=11 -> 16'h0000.
// - POS_WIDTH=10: i=12, mode=00 -> m_pos=0, m_oor=1.
//   Same i=12 with mode=01 -> m_pos=10'h3FF, m_oor=1.
// - CHANNELS=3, s_bin={4'd2,4'd0,4'd15} -> m_pos={16'h0004,16'h0001,16'h8000}.
// - Backpressure: m_ready=0 for 5 clk during 4 offered beats
//   -> s_ready=0 after 2 accepts, m_pos stable; release -> beats in order, no loss.
// - rst pulse with skid full -> m_valid=0, s_ready=1 immediately.
//   With BIN2POS_ERR_CNT_EN, 3 oor beats -> err_cnt=3; err_clr with oor beat -> err_cnt=0.

Source files
------------

// File: rtl/bin2pos_if.sv
// Stream bundle for bin2pos_pipe: index beats in (s_*), position-vector beats out (m_*).
// slave = decoder side, master = producer/consumer environment side.
interface bin2pos_if #(
  parameter int BIN_WIDTH = 4,
  parameter int POS_WIDTH = 2**BIN_WIDTH,
  parameter int CHANNELS  = 1
);
  logic [1:0]                    mode;
  logic                          s_valid;
  logic                          s_ready;
  logic [CHANNELS*BIN_WIDTH-1:0] s_bin;
  logic                          m_valid;
  logic                          m_ready;
  logic [CHANNELS*POS_WIDTH-1:0] m_pos;
  logic [CHANNELS-1:0]           m_oor;

  modport slave (
    input  mode, s_valid, s_bin, m_ready,
    output s_ready, m_valid, m_pos, m_oor
  );

  modport master (
    output mode, s_valid, s_bin, m_ready,
    input  s_ready, m_valid, m_pos, m_oor
  );
endinterface

// File: rtl/bin2pos_pipe.sv
// Multi-channel binary-to-position decoder (one-hot / thermometer) with output reg + skid buffer.
// Optional out-of-range beat counter enabled by defining BIN2POS_ERR_CNT_EN.
module bin2pos_pipe #(
  parameter int BIN_WIDTH     = 4,
  parameter int POS_WIDTH     = 2**BIN_WIDTH,
  parameter int CHANNELS      = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  bin2pos_if.slave                 bus,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);
  localparam int POS_BITS = CHANNELS * POS_WIDTH;

  logic [POS_BITS-1:0] dec_pos;
  logic [CHANNELS-1:0] dec_oor;
  logic [POS_BITS-1:0] out_pos_reg, skid_pos_reg;
  logic [CHANNELS-1:0] out_oor_reg, skid_oor_reg;
  logic                out_valid_reg, skid_valid_reg;
  logic                accept, out_free;

  // Out-of-range indices fall out of these comparisons naturally:
  // one-hot never matches, both thermometer codes saturate to all ones.
  function automatic logic [POS_WIDTH-1:0] decode(input logic [BIN_WIDTH-1:0] bin,
                                                  input logic [1:0] md);
    logic [POS_WIDTH-1:0] v;
    int                   idx;
    v   = '0;
    idx = 32'(bin);
    for (int k = 0; k < POS_WIDTH; k++) begin
      case (md)
        2'b00:   v[k] = (k == idx);
        2'b01:   v[k] = (k <= idx);
        2'b10:   v[k] = (k < idx);
        default: v[k] = 1'b0;
      endcase
    end
    return v;
  endfunction

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [BIN_WIDTH-1:0] ch_bin;
    assign ch_bin = bus.s_bin[gi*BIN_WIDTH +: BIN_WIDTH];
    assign dec_pos[gi*POS_WIDTH +: POS_WIDTH] = decode(ch_bin, bus.mode);
    assign dec_oor[gi] = (32'(ch_bin) >= 32'(POS_WIDTH));
  end

  assign accept   = bus.s_valid & ~skid_valid_reg;
  assign out_free = ~out_valid_reg | bus.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pos_reg    <= '0;
      out_oor_reg    <= '0;
      out_valid_reg  <= 1'b0;
      skid_pos_reg   <= '0;
      skid_oor_reg   <= '0;
      skid_valid_reg <= 1'b0;
    end else if (out_free) begin
      // Skid has priority so ordering is kept; s_ready is low whenever the skid is full.
      if (skid_valid_reg) begin
        out_pos_reg    <= skid_pos_reg;
        out_oor_reg    <= skid_oor_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_pos_reg   <= dec_pos;
        out_oor_reg   <= dec_oor;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_pos_reg   <= dec_pos;
      skid_oor_reg   <= dec_oor;
      skid_valid_reg <= 1'b1;
    end
  end

  assign bus.s_ready = ~skid_valid_reg;
  assign bus.m_valid = out_valid_reg;
  assign bus.m_pos   = out_pos_reg;
  assign bus.m_oor   = out_oor_reg;

`ifdef BIN2POS_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      err_cnt_reg <= '0;
    end else if (out_valid_reg && bus.m_ready && (|out_oor_reg) && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign err_cnt        = '0;
`endif
endmodule
